// File: rtl/icache_burst_mem_responder_if.sv
`default_nettype none
// ============================================================================
// icache_burst_mem_responder_if : I-Cache refill request/response bundle
// Revision 1.0
// ============================================================================
interface icache_burst_mem_responder_if;
  logic        from_cache_rd_req_valid;
  logic [31:0] from_cache_rd_req_addr;
  logic        to_cache_rd_req_ready;
  logic        to_cache_rd_rsp_valid;
  logic [31:0] to_cache_rd_rsp_data;
  logic        to_cache_rd_rsp_last;
  logic        from_cache_rd_rsp_ready;

  // Cache side drives requests and the response back-pressure.
  modport master (
    output from_cache_rd_req_valid,
    output from_cache_rd_req_addr,
    output from_cache_rd_rsp_ready,
    input  to_cache_rd_req_ready,
    input  to_cache_rd_rsp_valid,
    input  to_cache_rd_rsp_data,
    input  to_cache_rd_rsp_last
  );

  modport slave (
    input  from_cache_rd_req_valid,
    input  from_cache_rd_req_addr,
    input  from_cache_rd_rsp_ready,
    output to_cache_rd_req_ready,
    output to_cache_rd_rsp_valid,
    output to_cache_rd_rsp_data,
    output to_cache_rd_rsp_last
  );
endinterface
`default_nettype wire

// File: rtl/icache_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// icache_burst_mem_responder : backdoor-loaded memory returning 8-beat line bursts
// Revision 1.0
// ============================================================================
module icache_burst_mem_responder #(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  icache_burst_mem_responder_if.slave        bus,
  input  logic                               init_wen,
  input  logic [31:0]                        init_addr,
  input  logic [31:0]                        init_wdata,
  output logic                               busy,
  output logic [31:0]                        burst_count
);

  localparam int unsigned    BEAT_W    = $clog2(BURST_LEN);
  localparam int unsigned    LINE_W    = MEM_AW - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [3:0]     LAT_INIT  = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t              state_q;
  logic [LINE_W-1:0]   base_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [3:0]          lat_q;
  logic                valid_q;
  logic                last_q;
  logic [31:0]         count_q;

  logic [31:0]         mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]   rd_idx;
  logic [MEM_AW-1:0]   wr_idx;
  logic                rsp_hs;

  // Line base keeps only the index bits; higher address bits alias.
  assign rd_idx = {base_q, beat_q};
  assign wr_idx = init_addr[MEM_AW+1:2];
  assign rsp_hs = valid_q && bus.from_cache_rd_rsp_ready;

  // Asynchronous read: a write lands at the edge, so the old word is seen
  // for the rest of the write cycle and the new word from the next cycle.
  always_ff @(posedge clk) begin
    if (init_wen) begin
      mem_q[wr_idx] <= init_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      lat_q   <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.from_cache_rd_req_valid) begin
            base_q <= bus.from_cache_rd_req_addr[LINE_W+BEAT_W+1:BEAT_W+2];
            beat_q <= '0;
            lat_q  <= LAT_INIT;
            if (LATENCY == 0) begin
              state_q <= ST_SEND;
              valid_q <= 1'b1;
              last_q  <= (LAST_BEAT == '0);
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q <= 4'd1) begin
            state_q <= ST_SEND;
            valid_q <= 1'b1;
            last_q  <= (LAST_BEAT == '0);
          end
        end

        ST_SEND: begin
          if (rsp_hs) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              beat_q  <= '0;
              count_q <= count_q + 32'd1;
            end else begin
              beat_q <= beat_q + 1'b1;
              last_q <= ((beat_q + 1'b1) == LAST_BEAT);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.to_cache_rd_req_ready = (state_q == ST_IDLE);
  assign bus.to_cache_rd_rsp_valid = valid_q;
  assign bus.to_cache_rd_rsp_last  = last_q;
  assign bus.to_cache_rd_rsp_data  = valid_q ? mem_q[rd_idx] : 32'd0;

  assign busy        = (state_q != ST_IDLE);
  assign burst_count = count_q;

endmodule
`default_nettype wire

// File: doc/icache_burst_mem_responder.md
Name: icache_burst_mem_responder

Overview:
Memory-side responder for the I-Cache refill interface. It accepts 32-byte-aligned line read requests and returns each line as an 8-beat burst of 32-bit words, tagging the final beat with last. It is backed by an internal word array that the bench or loader fills through a backdoor write port. It stands in for the memory at the I-Cache's refill port in unit benches and on-chip standalone configurations.

Parameters:
MEM_AW, 12, word-address bits of the internal array (depth 2^MEM_AW words).
BURST_LEN, 8, beats per burst; fixed to one 32-byte line.
LATENCY, 2, idle cycles between request acceptance and first beat (0 allowed, max 15).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
from_cache_rd_req_valid  in  1  line read request valid
from_cache_rd_req_addr  in  32  request byte address; bits [4:0] ignored
to_cache_rd_req_ready  out  1  responder can accept a request
to_cache_rd_rsp_valid  out  1  current beat valid
to_cache_rd_rsp_data  out  32  current beat word
to_cache_rd_rsp_last  out  1  current beat is the final beat of the burst
from_cache_rd_rsp_ready  in  1  cache accepts current beat
init_wen  in  1  backdoor word write enable
init_addr  in  32  backdoor byte address; word index = init_addr[MEM_AW+1:2]
init_wdata  in  32  backdoor write data
busy  out  1  burst in progress (state not IDLE)
burst_count  out  32  completed bursts, wraps at 2^32

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, WAIT, SEND.
- Reset: state IDLE; beat counter 0; latency counter 0; burst_count 0; rsp_valid 0; rsp_last 0; rsp_data 0. to_cache_rd_req_ready is 1 in the first cycle after rst deasserts. Array contents are not cleared.
- to_cache_rd_req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- IDLE: on valid&&ready, latch line base = addr[31:5], clear beat to 0, and load the latency counter with LATENCY. Next state is WAIT, or SEND directly if LATENCY==0.
- WAIT: decrement the counter each cycle; go to SEND when the counter reaches 1. The first beat is valid exactly LATENCY+1 cycles after the accept edge.
- SEND:
  - rsp_valid = 1.
  - rsp_data = mem[(base*8 + beat) mod 2^MEM_AW].
  - rsp_last = (beat == BURST_LEN-1).
  - While valid && !ready, data and last hold stable, provided no backdoor write hits that word.
  - On each handshake, beat increments.
  - On the last-beat handshake: go to IDLE, increment burst_count, and rsp_valid drops the next cycle.
- Request address bits above MEM_AW+1 are ignored (aliasing); there is no error response.
- Bursts never wrap inside a line: beat 0 is always word 0 of the line.
- Outside SEND: rsp_valid = 0, rsp_last = 0, rsp_data = 0.
- A req_valid arriving while busy is not accepted; it must be held by the requester until ready.
- Backdoor write: on init_wen, the word is written at the clock edge in any state. A beat presented afterward reflects the new value. Simultaneous write and read of the same word returns the old value in that cycle.
- rst asserted mid-burst: the burst is abandoned and there is no last beat. The next cycle shows valid=0, ready=1.
- busy = (state != IDLE).

Test Plan:
- Preload words 0..15 with 0x1000+i, LATENCY=2. Request addr 0x0000_0020 with rsp_ready held 1 -> valid first rises 3 cycles after accept; data 0x1008..0x100F on consecutive cycles; last only on 0x100F; burst_count=1; ready=1 the next cycle.
- Request addr 0x0000_003C (unaligned) -> same burst as 0x20: 8 beats starting 0x1008.
- Toggle rsp_ready 1,0,0,1,... during a burst -> each beat holds stable while ready=0; exactly 8 handshakes; no beat skipped or duplicated.
- LATENCY=0: request accepted at cycle T -> first beat valid at T+1.
- Hold req_valid high during a burst with a different addr -> not accepted until IDLE; second burst returns the second line's data.
- Assert rst after the 3rd beat handshake -> next cycle valid=0, ready=1, burst_count unchanged; a fresh request then returns a full 8-beat burst.
